hpu_phase_ctrl: RTL and testbench

Top-level sequencer for the HPU datapath. It replaces the free-running run/gen register bits with a controlled phase machine: item-memory generation (gen), then encode/stream (run), then completion. It latches the operand configuration, drives the item-memory address counter and the random-seed capture strobe, and tracks stream completion. It also provides a progress watchdog. It sits between the AXI-Lite register file and get_enable/get_ctrl/buffer_ctrl/stream_ctrl/core.

---
 rtl/hpu_phase_ctrl.sv | 137 +++++++++++++
 tb/tb_hpu_phase_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_phase_ctrl.sv
// Phase sequencer for the HPU datapath: item-memory generation, then streaming run, then completion.
// Latches operand configuration, drives item addressing and seed capture, and watches stream progress.
module hpu_phase_ctrl #(
  parameter int ITEM_W = 16,
  parameter int ADDR_W = 20,
  parameter int TO_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_gen,
  input  logic              start_run,
  input  logic              abort,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic              get_fin,
  input  logic              dst_valid,
  input  logic              dst_ready,
  input  logic              dst_last,
  output logic              gen,
  output logic              run,
  output logic [ITEM_W-1:0] item_a,
  output logic              rand_load,
  output logic [ITEM_W-1:0] item_memory_num,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic              err_busy,
  output logic              err_timeout,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // The watchdog fires on the cycle its counter would step onto all-ones.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          cur, nxt;
  logic [TO_W-1:0] wd;
  logic            last_seen;
  logic            beat, last_beat, streaming, busy_s, settled;
  logic            wd_clear, timeout, gen_last;
  logic            accept_gen, accept_run, busy_cmd;

  assign beat      = dst_valid & dst_ready;
  assign last_beat = beat & dst_last;
  assign streaming = (cur == S_RUN) || (cur == S_DRAIN);
  assign busy_s    = (cur == S_GEN) || streaming;
  assign settled   = (cur == S_IDLE) || (cur == S_READY) || (cur == S_DONE);
  assign wd_clear  = beat | get_fin;
  assign timeout   = streaming && !wd_clear && (wd == WD_LAST);
  assign gen_last  = (cur == S_GEN) && (item_a == item_memory_num);

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    accept_gen = 1'b0;
    accept_run = 1'b0;
    busy_cmd   = 1'b0;
    case (cur)
      S_IDLE, S_READY, S_DONE: nxt = cur;
      S_GEN:   if (gen_last) nxt = S_READY;
      S_RUN:   if (get_fin) nxt = (last_seen || last_beat) ? S_DONE : S_DRAIN;
      S_DRAIN: if (last_beat) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
    // Commands arriving mid-phase are refused but the phase keeps progressing.
    if (abort || timeout) begin
      nxt = S_IDLE;
    end else if (busy_s && (start_gen || start_run)) begin
      busy_cmd = 1'b1;
    end else if (settled && start_gen) begin
      accept_gen = 1'b1;
      nxt        = S_GEN;
    end else if (start_run && ((cur == S_READY) || (cur == S_DONE))) begin
      accept_run = 1'b1;
      nxt        = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      item_a          <= '0;
      item_memory_num <= '0;
      addr_i          <= '0;
      addr_j          <= '0;
      err_busy        <= 1'b0;
      err_timeout     <= 1'b0;
      last_seen       <= 1'b0;
      wd              <= '0;
    end else begin
      if (accept_gen) begin
        item_memory_num <= cfg_item_num;
        addr_i          <= cfg_addr_i;
        addr_j          <= cfg_addr_j;
        item_a          <= '0;
        err_busy        <= 1'b0;
        err_timeout     <= 1'b0;
      end else begin
        if (accept_run) begin
          addr_i <= cfg_addr_i;
          addr_j <= cfg_addr_j;
        end
        if ((cur == S_GEN) && (nxt == S_GEN)) item_a <= item_a + ITEM_W'(1);
        if (busy_cmd) err_busy <= 1'b1;
        if (timeout) err_timeout <= 1'b1;
      end
      if (streaming && ((nxt == S_RUN) || (nxt == S_DRAIN))) begin
        last_seen <= last_seen | last_beat;
        wd        <= wd_clear ? '0 : wd + TO_W'(1);
      end else begin
        last_seen <= 1'b0;
        wd        <= '0;
      end
    end
  end

  assign gen       = (cur == S_GEN);
  assign run       = streaming;
  assign busy      = busy_s;
  assign done      = (cur == S_DONE);
  assign rand_load = gen_last & addr_i[0];
  assign state     = cur;

endmodule

// File: tb/tb_hpu_phase_ctrl.sv
// Self-checking bench for hpu_phase_ctrl: a vector table, directed phase sequences,
// and randomized traffic compared each cycle against a phase-level reference model.
module tb_hpu_phase_ctrl;

  localparam int ITEM_W = 16;
  localparam int ADDR_W = 20;
  localparam int TO_W   = 4;
  localparam int WD_LIMIT = (1 << TO_W) - 1;

  logic              clk;
  logic              rst, start_gen, start_run, abort;
  logic [ITEM_W-1:0] cfg_item_num;
  logic [ADDR_W-1:0] cfg_addr_i, cfg_addr_j;
  logic              get_fin, dst_valid, dst_ready, dst_last;
  logic              gen, run, rand_load, busy, done, err_busy, err_timeout;
  logic [ITEM_W-1:0] item_a, item_memory_num;
  logic [ADDR_W-1:0] addr_i, addr_j;
  logic [2:0]        state;

  int n_checks = 0;
  int n_fail   = 0;

  hpu_phase_ctrl #(.ITEM_W(ITEM_W), .ADDR_W(ADDR_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .start_gen(start_gen), .start_run(start_run), .abort(abort),
    .cfg_item_num(cfg_item_num), .cfg_addr_i(cfg_addr_i), .cfg_addr_j(cfg_addr_j),
    .get_fin(get_fin), .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_last(dst_last),
    .gen(gen), .run(run), .item_a(item_a), .rand_load(rand_load),
    .item_memory_num(item_memory_num), .addr_i(addr_i), .addr_j(addr_j),
    .busy(busy), .done(done), .err_busy(err_busy), .err_timeout(err_timeout), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: phase number (0 idle, 1 gen, 2 ready, 3 run, 4 drain, 5 done)
  // plus the counters the rules talk about.
  int              m_phase;
  logic [ITEM_W-1:0] m_item_a, m_num;
  logic [ADDR_W-1:0] m_ai, m_aj;
  bit              m_last, m_eb, m_et;
  int              m_quiet;

  task automatic stepModel();
    bit act, hsl, in_stream, busy_now;
    if (rst) begin
      m_phase = 0; m_item_a = '0; m_num = '0; m_ai = '0; m_aj = '0;
      m_last = 0; m_eb = 0; m_et = 0; m_quiet = 0;
      return;
    end
    if (abort) begin
      m_phase = 0; m_last = 0; m_quiet = 0;
      return;
    end
    in_stream = (m_phase == 3) || (m_phase == 4);
    act       = (dst_valid && dst_ready) || get_fin;
    hsl       = dst_valid && dst_ready && dst_last;
    if (in_stream && !act && (m_quiet + 1 == WD_LIMIT)) begin
      m_et = 1; m_phase = 0; m_quiet = 0; m_last = 0;
      return;
    end
    busy_now = (m_phase == 1) || in_stream;
    if (busy_now && (start_gen || start_run)) m_eb = 1;
    if (!busy_now && start_gen) begin
      m_num = cfg_item_num; m_ai = cfg_addr_i; m_aj = cfg_addr_j;
      m_item_a = '0; m_eb = 0; m_et = 0; m_last = 0; m_quiet = 0;
      m_phase = 1;
      return;
    end
    if (start_run && !start_gen && (m_phase == 2 || m_phase == 5)) begin
      m_ai = cfg_addr_i; m_aj = cfg_addr_j;
      m_last = 0; m_quiet = 0; m_phase = 3;
      return;
    end
    case (m_phase)
      1: if (m_item_a == m_num) m_phase = 2; else m_item_a = m_item_a + 1'b1;
      3: begin
        m_quiet = act ? 0 : m_quiet + 1;
        if (hsl) m_last = 1;
        if (get_fin) m_phase = m_last ? 5 : 4;
      end
      4: begin
        m_quiet = act ? 0 : m_quiet + 1;
        if (hsl) m_phase = 5;
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic checkModel();
    logic [127:0] dv_v, mv_v;
    bit m_gen, m_run, m_busy, m_done, m_rl;
    m_gen  = (m_phase == 1);
    m_run  = (m_phase == 3) || (m_phase == 4);
    m_busy = m_gen || m_run;
    m_done = (m_phase == 5);
    m_rl   = m_gen && (m_item_a == m_num) && m_ai[0];
    dv_v = {46'd0, state, gen, run, busy, done, rand_load, err_busy, err_timeout,
            item_a, item_memory_num, addr_i, addr_j};
    mv_v = {46'd0, 3'(m_phase), m_gen, m_run, m_busy, m_done, m_rl, m_eb, m_et,
            m_item_a, m_num, m_ai, m_aj};
    checkOutput("model", dv_v, mv_v);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare after settling.
  task automatic applyStimulus(input logic r, input logic sg, input logic sr, input logic ab,
                               input logic gf, input logic v, input logic rd, input logic l);
    rst = r; start_gen = sg; start_run = sr; abort = ab;
    get_fin = gf; dst_valid = v; dst_ready = rd; dst_last = l;
    @(posedge clk);
    stepModel();
    #1;
    checkModel();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic       r, sg, sr, ab, gf, v, rd, l;
    logic [2:0] st;
    logic       g, ru, bu, dn, rl, eb, et;
    logic [15:0] ia;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int gen_cnt, bad, rl_cnt, run_bad, saw_drain, run_cnt;
    logic [ITEM_W-1:0] rl_item, hold_a;
    logic rl_gen;

    rst = 1; start_gen = 0; start_run = 0; abort = 0; get_fin = 0;
    dst_valid = 0; dst_ready = 0; dst_last = 0;
    cfg_item_num = 16'd2; cfg_addr_i = 20'd3; cfg_addr_j = 20'd5;

    //            r  sg sr ab gf v  rd l   st g  ru bu dn rl eb et ia
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 1, 1, 0, 2};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 1, 0, 2};
    tbl[6]  = '{0, 0, 1, 0, 0, 0, 0, 0,  3, 0, 1, 1, 0, 0, 1, 0, 2};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, 1,  3, 0, 1, 1, 0, 0, 1, 0, 2};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 0,  5, 0, 0, 0, 1, 0, 1, 0, 2};
    tbl[9]  = '{0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].r, tbl[i].sg, tbl[i].sr, tbl[i].ab,
                    tbl[i].gf, tbl[i].v, tbl[i].rd, tbl[i].l);
      checkOutput($sformatf("vec%0d", i),
        {101'd0, state, gen, run, busy, done, rand_load, err_busy, err_timeout, item_a},
        {101'd0, tbl[i].st, tbl[i].g, tbl[i].ru, tbl[i].bu, tbl[i].dn, tbl[i].rl,
         tbl[i].eb, tbl[i].et, tbl[i].ia});
    end

    // Long generation with even addr_i: no seed capture at all.
    cfg_item_num = 16'd1000; cfg_addr_i = 20'd110; cfg_addr_j = 20'd5;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    gen_cnt = 0; bad = 0; rl_cnt = 0;
    while (gen && gen_cnt < 1100) begin
      if (item_a != ITEM_W'(gen_cnt) || state != 3'd1) bad++;
      if (rand_load) rl_cnt++;
      gen_cnt++;
      idleCycle();
    end
    checkOutput("gen_len_even", 128'(gen_cnt), 128'd1001);
    checkOutput("gen_addr_seq", 128'(bad), 128'd0);
    checkOutput("rand_none", 128'(rl_cnt), 128'd0);
    checkOutput("gen_to_ready", 128'(state), 128'd2);

    // Odd addr_i: one capture strobe on the final generation cycle.
    cfg_addr_i = 20'd7;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    gen_cnt = 0; rl_cnt = 0; rl_item = '0; rl_gen = 0;
    while (gen && gen_cnt < 1100) begin
      if (rand_load) begin rl_cnt++; rl_item = item_a; rl_gen = gen; end
      gen_cnt++;
      idleCycle();
    end
    checkOutput("gen_len_odd", 128'(gen_cnt), 128'd1001);
    checkOutput("rand_once", 128'(rl_cnt), 128'd1);
    checkOutput("rand_at_last", {111'd0, rl_gen, rl_item}, {111'd0, 1'b1, 16'd1000});
    checkOutput("item_hold", 128'(item_a), 128'd1000);

    // Run with get_fin at cycle 50 and the last beat at cycle 58.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    run_bad = 0;
    for (int k = 1; k <= 58; k++) begin
      if (!run) run_bad++;
      if (k == 51) checkOutput("drain_entered", 128'(state), 128'd4);
      if (k < 50)       applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
      else if (k == 50) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      else if (k == 58) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
      else              idleCycle();
    end
    checkOutput("run_high", 128'(run_bad), 128'd0);
    checkOutput("done_after_drain", {123'd0, state, done, run}, {123'd0, 3'd5, 1'b1, 1'b0});

    // Last beat coincident with get_fin goes straight to DONE.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("rerun_from_done", {124'd0, state, done}, {124'd0, 3'd3, 1'b0});
    saw_drain = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
      else       applyStimulus(0, 0, 0, 0, 1, 1, 1, 1);
      if (state == 3'd4) saw_drain++;
    end
    checkOutput("direct_done", {123'd0, state, done, run}, {123'd0, 3'd5, 1'b1, 1'b0});
    checkOutput("no_drain", 128'(saw_drain), 128'd0);

    // Commands while busy are refused and flagged.
    cfg_item_num = 16'd5;
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("run_in_gen", {124'd0, state, err_busy}, {124'd0, 3'd1, 1'b1});
    for (int k = 0; k < 20 && state != 3'd2; k++) idleCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    hold_a = item_a;
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 0);
    checkOutput("gen_in_run", {108'd0, state, err_busy, item_a},
                {108'd0, 3'd3, 1'b1, 16'd5});
    checkOutput("gen_in_run_hold", 128'(hold_a), 128'd5);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("abort_keeps_err", {124'd0, state, err_busy}, {124'd0, 3'd0, 1'b1});
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("err_busy_clear", {124'd0, state, err_busy}, {124'd0, 3'd1, 1'b0});

    // Watchdog: 15 idle RUN cycles then back to IDLE with err_timeout.
    for (int k = 0; k < 20 && state != 3'd2; k++) idleCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    run_cnt = 0;
    while (run && run_cnt < 40) begin
      run_cnt++;
      idleCycle();
    end
    checkOutput("wd_cycles", 128'(run_cnt), 128'(WD_LIMIT));
    checkOutput("wd_flag", {124'd0, state, err_timeout}, {124'd0, 3'd0, 1'b1});

    // Abort in the middle of generation.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("et_clear", 128'(err_timeout), 128'd0);
    idleCycle();
    idleCycle();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("abort_gen", {124'd0, state, gen}, {124'd0, 3'd0, 1'b0});

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      cfg_item_num = ITEM_W'($urandom_range(15));
      cfg_addr_i   = ADDR_W'($urandom);
      cfg_addr_j   = ADDR_W'($urandom);
      applyStimulus($urandom_range(299) == 0, $urandom_range(24) == 0,
                    $urandom_range(9) == 0,   $urandom_range(59) == 0,
                    $urandom_range(19) == 0,  $urandom_range(3) == 0,
                    $urandom_range(1) == 1,   $urandom_range(2) == 0);
    end

    // Reset mid-operation drops everything including configuration.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_clears",
      {46'd0, state, gen, run, busy, done, rand_load, err_busy, err_timeout,
       item_a, item_memory_num, addr_i, addr_j}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
